// File: rtl/sar_search.sv
// Purpose    : 8-bit successive-approximation search driving an external comparator.
// Latency    : start edge + 8 SEARCH cycles, done pulses in the 9th cycle (earlier on equality with SAR_EARLY_EXIT_EN).
// Backpressure: none; start is sampled only in IDLE and is ignored, not queued, while busy or done.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request a new search (sampled in IDLE only)
//   gt/lt  - comparator result for the current trial: target > trial / target < trial
//   trial  - registered candidate value presented to the comparator
//   busy   - high while searching
//   done   - one-cycle completion pulse
//   result - converged value, held until the next accepted start
//   exact  - equality was observed during the last search
//
// Optional feature: define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.

module sar_search (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gt,
    input  logic       lt,
    output logic [7:0] trial,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       exact
);

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] trial_q, trial_d;
    logic [7:0] result_q, result_d;
    logic       exact_q, exact_d;

    // Decision helpers for the bit currently under test.
    logic       eq;
    logic [7:0] idx_bit;
    logic [7:0] next_bit;
    logic [7:0] decided;

    always_comb begin
        // lt wins over gt, so an illegal gt=lt=1 clears the bit like a plain lt.
        eq       = ~gt & ~lt;
        idx_bit  = 8'd1 << idx_q;
        next_bit = idx_bit >> 1;
        decided  = lt ? (trial_q & ~idx_bit) : (trial_q | idx_bit);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        trial_d  = trial_q;
        result_d = result_q;
        exact_d  = exact_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    trial_d = 8'h80;
                    idx_d   = 3'd7;
                    exact_d = 1'b0;
                    state_d = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (eq) begin
                    exact_d = 1'b1;
                end

                if (EARLY_EXIT && eq) begin
                    // The current trial already matches; report it unchanged.
                    result_d = trial_q;
                    idx_d    = 3'd0;
                    state_d  = S_DONE;
                end else if (idx_q == 3'd0) begin
                    trial_d  = decided;
                    result_d = decided;
                    state_d  = S_DONE;
                end else begin
                    // Commit this bit and tentatively set the next lower one.
                    trial_d = decided | next_bit;
                    idx_d   = idx_q - 3'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            trial_q  <= 8'h00;
            result_q <= 8'h00;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            exact_q  <= exact_d;
        end
    end

    // Status outputs decode the state register directly so reset clears them at once.
    assign trial  = trial_q;
    assign busy   = (state_q == S_SEARCH);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign exact  = exact_q;

endmodule

// File: tb/tb_sar_search.sv
// Purpose    : self-checking bench for sar_search with a cycle model built from plain SAR arithmetic.
// Latency    : model tracks the DUT cycle by cycle; compare runs on every falling edge outside reset.
// Backpressure: not applicable; the bench plays the external comparator against a static target.

module tb_sar_search;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       gt;
    logic       lt;
    logic [7:0] trial;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       exact;

    logic [7:0] target;
    logic       force_both;

    int checks   = 0;
    int failures = 0;

    sar_search dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .gt     (gt),
        .lt     (lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparator; force_both drives the illegal gt=lt=1 combination.
    always_comb begin
        if (force_both) begin
            gt = 1'b1;
            lt = 1'b1;
        end else begin
            gt = (target > trial);
            lt = (target < trial);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Trial at decision step k: bits above the tested one equal the target, tested bit set.
    function automatic logic [7:0] step_trial(input logic [7:0] tgt, input int k);
        int hi_mask;
        hi_mask = 256 - (256 >> k);
        return 8'((int'(tgt) & hi_mask) | (128 >> k));
    endfunction

    // ---------------- behavioural model ----------------
    int         m_phase;   // 0 idle, 1 searching, 2 done
    int         m_step;
    logic [7:0] m_tgt;
    logic [7:0] m_trial;
    logic [7:0] m_result;
    logic       m_exact;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= 0;
            m_step   <= 0;
            m_tgt    <= 8'h00;
            m_trial  <= 8'h00;
            m_result <= 8'h00;
            m_exact  <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (start) begin
                        m_phase <= 1;
                        m_step  <= 0;
                        // Always answering "below" behaves like searching for zero.
                        m_tgt   <= force_both ? 8'h00 : target;
                        m_trial <= 8'h80;
                        m_exact <= 1'b0;
                    end
                end
                1: begin
                    if (EARLY && (m_trial == m_tgt)) begin
                        m_result <= m_trial;
                        m_exact  <= 1'b1;
                        m_phase  <= 2;
                    end else begin
                        if (m_trial == m_tgt) m_exact <= 1'b1;
                        if (m_step == 7) begin
                            m_trial  <= m_tgt;
                            m_result <= m_tgt;
                            m_phase  <= 2;
                        end else begin
                            m_step  <= m_step + 1;
                            m_trial <= step_trial(m_tgt, m_step + 1);
                        end
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",   int'(busy),   int'(m_phase == 1));
            chk("done",   int'(done),   int'(m_phase == 2));
            chk("trial",  int'(trial),  int'(m_trial));
            chk("result", int'(result), int'(m_result));
            if (m_phase != 1) chk("exact", int'(exact), int'(m_exact));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] seq[$];
    int         done_at;

    // mode 0: single start pulse, 1: start held high, 2: start toggled while busy
    task automatic run_search(input string nm, input logic [7:0] tgt, input logic both,
                              input int mode, input int exp_done,
                              input logic [7:0] exp_res, input logic exp_exact);
        @(negedge clk);
        target     = tgt;
        force_both = both;
        start      = 1'b1;
        done_at    = 0;
        seq.delete();
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            @(negedge clk);
            if (mode == 0) start = 1'b0;
            else if (mode == 2) start = ~start;
            if (busy) seq.push_back(trial);
            if (done) done_at = n;
        end
        if (mode != 1) start = 1'b0;
        chk({nm, "_done_cycle"}, done_at, exp_done);
        chk({nm, "_result"}, int'(result), int'(exp_res));
        chk({nm, "_exact"}, int'(exact), int'(exp_exact));
    endtask

    logic [7:0] seq_5a[8];
    int         gap;

    initial begin
        seq_5a[0] = 8'h80; seq_5a[1] = 8'h40; seq_5a[2] = 8'h60; seq_5a[3] = 8'h50;
        seq_5a[4] = 8'h58; seq_5a[5] = 8'h5C; seq_5a[6] = 8'h5A; seq_5a[7] = 8'h5B;

        rst        = 1'b1;
        start      = 1'b0;
        target     = 8'h00;
        force_both = 1'b0;
        #1;
        chk("reset_trial",  int'(trial),  0);
        chk("reset_busy",   int'(busy),   0);
        chk("reset_done",   int'(done),   0);
        chk("reset_result", int'(result), 0);
        chk("reset_exact",  int'(exact),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Worked example: 0x5A
        run_search("t5a", 8'h5A, 1'b0, 0, EARLY ? 8 : 9, 8'h5A, 1'b1);
        chk("t5a_seq_len", seq.size(), EARLY ? 7 : 8);
        for (int i = 0; i < seq.size() && i < 8; i++)
            chk($sformatf("t5a_seq%0d", i), int'(seq[i]), int'(seq_5a[i]));

        // Extremes
        run_search("t00", 8'h00, 1'b0, 0, 9, 8'h00, 1'b0);
        run_search("tff", 8'hFF, 1'b0, 0, 9, 8'hFF, 1'b1);
        if (seq.size() > 0) chk("tff_last_trial", int'(seq[seq.size() - 1]), 8'hFF);
        else chk("tff_seq_len", 0, 8);
        chk("tff_trial_after", int'(trial), 8'hFF);

        // Equality on the very first trial
        run_search("t80", 8'h80, 1'b0, 0, EARLY ? 2 : 9, 8'h80, 1'b1);

        // Illegal gt=lt=1: lt wins, every bit is cleared
        run_search("tboth", 8'h77, 1'b1, 0, 9, 8'h00, 1'b0);
        force_both = 1'b0;

        // start toggled while busy must not disturb the search
        run_search("ttog", 8'h5A, 1'b0, 2, EARLY ? 8 : 9, 8'h5A, 1'b1);

        // start held high: one search per IDLE entry, next done 10 cycles later
        run_search("thold", 8'h01, 1'b0, 1, 9, 8'h01, 1'b1);
        gap = 0;
        for (int n = 1; n <= 20 && gap == 0; n++) begin
            @(negedge clk);
            if (done) gap = n;
        end
        chk("thold_gap", gap, 10);
        chk("thold_result2", int'(result), 8'h01);
        start = 1'b0;

        // Asynchronous reset in the middle of a search
        @(negedge clk);
        target = 8'h5A;
        start  = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_pre_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_trial",  int'(trial),  0);
        chk("rst_async_busy",   int'(busy),   0);
        chk("rst_async_done",   int'(done),   0);
        chk("rst_async_result", int'(result), 0);
        chk("rst_async_exact",  int'(exact),  0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("rst_no_done", int'(done), 0);
        end
        run_search("t33", 8'h33, 1'b0, 0, 9, 8'h33, 1'b1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
